alu_resp: RTL and testbench
===========================

Name: alu_resp

Overview:
- Pipelined, handshaked ALU responder.
- Accepts operation requests (a, b, select) on a valid/ready request port.
- Returns the result plus zero/carry/sign/parity/overflow flags on a valid/ready response port.
- Sits between a request initiator (stimulus generator, sequencer or CPU datapath) and a result consumer; sustains one operation per cycle under no backpressure.

Parameters:
- WIDTH, 4, operand and result width in bits (min 2).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept request this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- select  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 XOR
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response this cycle
- out  output  WIDTH  result
- zero  output  1  out == 0
- carry  output  1  ADD carry-out / SUB no-borrow; 0 for logic ops
- sign  output  1  out[WIDTH-1]
- parity  output  1  XOR-reduction of out (1 = odd count of ones)
- overflow  output  1  signed two's-complement overflow for ADD/SUB; 0 for logic ops
- txn_count  output  CNT_W  number of completed response handshakes, wraps

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- On reset: s1_valid=0, s2_valid=0, rsp_valid=0, out=0, all flags=0, txn_count=0. req_ready is 1 in the first cycle after reset release.
- Reset mid-operation: all in-flight requests are discarded, with no response emitted.
- Handshakes:
  - Request transfers when req_valid && req_ready at a clock edge.
  - Response transfers when rsp_valid && rsp_ready at a clock edge.
  - While rsp_valid=1 and rsp_ready=0, out and flags are held stable.
- Pipeline:
  - Stage 1 registers a, b, select on acceptance.
  - Stage 2 registers the computed result and flags.
  - s2 loads when s1_valid && (!s2_valid || rsp_ready).
  - s1 loads on acceptance, and clears when it advances without a new accept.
  - req_ready = !s1_valid || !s2_valid || rsp_ready (combinational from rsp_ready; no combinational path from req_valid to req_ready).
  - rsp_valid = s2_valid.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N+1, provided stage 2 is free.
- Throughput: 1 op/cycle with rsp_ready held high.
- Capacity: 2 ops in flight maximum; with rsp_ready=0, req_ready drops once both stages are full.
- Ordering: responses are strictly in request order; no drop, no duplicate.
- Arithmetic: compute at WIDTH+1 bits.
  - ADD: {carry,out} = a + b.
  - SUB: {carry,out} = a + ~b + 1, so carry=1 means no borrow (a >= b unsigned).
  - overflow (ADD) = (a[MSB]==b[MSB]) && (out[MSB]!=a[MSB]).
  - overflow (SUB) = (a[MSB]!=b[MSB]) && (out[MSB]!=a[MSB]).
  - AND/XOR: carry=0, overflow=0.
- Flags are computed from the stage-1 operands and registered together with out.
- Simultaneous response handshake and s1 advance: s2 is replaced in the same edge; no bubble.
- txn_count increments on each response handshake and wraps from 2^CNT_W-1 to 0.
- Inputs a, b, select are don't-care when req_valid=0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11;
  - flag bit indices for packing {overflow,parity,sign,carry,zero}.
- One natural sub-module, alu_core: purely combinational; inputs a, b, select; outputs out and the five flags. Instantiated between stage 1 and stage 2.
- The top level holds the handshake, pipeline registers and counter.

Test Plan:
- ADD a=0111 b=0001, rsp_ready=1 -> after 2 edges out=1000 sign=1 overflow=1 carry=0 zero=0 parity=1.
- SUB a=0101 b=0101 -> out=0000 zero=1 carry=1 overflow=0 parity=0; then SUB a=0010 b=0011 -> out=1111 carry=0 sign=1 parity=0.
- AND a=1100 b=1010 -> out=1000 carry=0 overflow=0; XOR a=1100 b=1010 -> out=0110 parity=0.
- Backpressure: rsp_ready=0, 3 requests offered on consecutive cycles -> 2 accepted, req_ready=0 on the third, out held stable. Raise rsp_ready -> 3 responses in order, txn_count=3.
- Throughput: 4 back-to-back requests with rsp_ready=1 -> rsp_valid high for 4 consecutive cycles starting at the 2nd edge after the first accept, txn_count=4.
- Reset: rst_n=0 for one edge with 2 ops in flight -> rsp_valid=0, txn_count=0, outputs 0, req_ready=1 the next cycle, and no stale response appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag-vector layout and small flag helpers for the
// alu_resp responder and its combinational core.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Flag vector layout: {overflow, parity, sign, carry, zero}
  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_CARRY  = 1;
  localparam int FLAG_SIGN   = 2;
  localparam int FLAG_PARITY = 3;
  localparam int FLAG_OVF    = 4;
  localparam int FLAG_W      = 5;

  localparam int PAR_MAX_W = 64;

  function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

  // Signed overflow: ADD needs equal operand signs, SUB needs differing ones;
  // in both cases the result sign must have left the sign of a.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic same_s;
    same_s = (a_msb == b_msb);
    return (is_sub ? !same_s : same_s) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes the result at WIDTH+1 bits and derives the
// zero/carry/sign/parity/overflow flags from it.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [1:0]        select_i,
  output logic [WIDTH-1:0]  out_o,
  output logic [FLAG_W-1:0] flags_o
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] wide_s;
  logic           ovf_s;

  // Opcode decode; SUB is a + ~b + 1 so the carry-out means "no borrow".
  always_comb begin
    wide_s = '0;
    ovf_s  = 1'b0;
    case (select_i)
      OP_ADD: begin
        wide_s = {1'b0, a_i} + {1'b0, b_i};
        ovf_s  = signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], wide_s[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        wide_s = {1'b0, a_i} + {1'b0, ~b_i} + ONE;
        ovf_s  = signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], wide_s[WIDTH-1], 1'b1);
      end
      OP_AND: begin
        wide_s = {1'b0, a_i & b_i};
        ovf_s  = 1'b0;
      end
      OP_XOR: begin
        wide_s = {1'b0, a_i ^ b_i};
        ovf_s  = 1'b0;
      end
      default: begin
        wide_s = '0;
        ovf_s  = 1'b0;
      end
    endcase
  end

  // Flag packing; logic ops force carry to 0 through the zero top bit.
  always_comb begin
    out_o                = wide_s[WIDTH-1:0];
    flags_o              = '0;
    flags_o[FLAG_ZERO]   = (wide_s[WIDTH-1:0] == '0);
    flags_o[FLAG_CARRY]  = wide_s[WIDTH];
    flags_o[FLAG_SIGN]   = wide_s[WIDTH-1];
    flags_o[FLAG_PARITY] = odd_parity(PAR_MAX_W'(wide_s[WIDTH-1:0]));
    flags_o[FLAG_OVF]    = ovf_s;
  end

endmodule

// File: rtl/alu_resp.sv
// Two-stage valid/ready ALU responder: stage 1 captures the request operands,
// stage 2 holds the registered result and flags until the consumer takes them.
module alu_resp
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             overflow,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [WIDTH-1:0]  s1_b_q, s1_b_d;
  logic [1:0]        s1_sel_q, s1_sel_d;
  logic              s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  txn_q, txn_d;

  logic              accept_s;
  logic              s2_load_s;
  logic              rsp_fire_s;
  logic [WIDTH-1:0]  core_out_s;
  logic [FLAG_W-1:0] core_flags_s;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .select_i (s1_sel_q),
    .out_o    (core_out_s),
    .flags_o  (core_flags_s)
  );

  // Handshake decode; req_ready depends only on pipeline state and rsp_ready.
  always_comb begin
    req_ready  = !s1_valid_q || !s2_valid_q || rsp_ready;
    accept_s   = req_valid && req_ready;
    s2_load_s  = s1_valid_q && (!s2_valid_q || rsp_ready);
    rsp_fire_s = s2_valid_q && rsp_ready;
  end

  // Next-state for both stages and the completed-response counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_sel_d   = select;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    flags_d    = flags_q;
    // A load in the same edge as a response handshake replaces s2 without a bubble.
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
      out_d      = core_out_s;
      flags_d    = core_flags_s;
    end else if (rsp_fire_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (rsp_fire_s) begin
      txn_d = txn_q + CNT_ONE;
    end else begin
      txn_d = txn_q;
    end
  end

  // Pipeline state; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sel_q   <= 2'b00;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      flags_q    <= '0;
      txn_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sel_q   <= s1_sel_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      flags_q    <= flags_d;
      txn_q      <= txn_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign out       = out_q;
  assign zero      = flags_q[FLAG_ZERO];
  assign carry     = flags_q[FLAG_CARRY];
  assign sign      = flags_q[FLAG_SIGN];
  assign parity    = flags_q[FLAG_PARITY];
  assign overflow  = flags_q[FLAG_OVF];
  assign txn_count = txn_q;

endmodule

// File: tb/tb_alu_resp.sv
// Self-checking bench for alu_resp: directed scenario tasks plus a scoreboard
// that predicts every response from an integer reference model.
module tb_alu_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  a = 4'h0;
  logic [3:0]  b = 4'h0;
  logic [1:0]  select = 2'b00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [3:0]  out;
  logic        zero, carry, sign, parity, overflow;
  logic [15:0] txn_count;

  int total = 0;
  int bad = 0;
  logic [8:0] sb_q[$];

  alu_resp #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .select(select), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .out(out), .zero(zero), .carry(carry), .sign(sign), .parity(parity),
    .overflow(overflow), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, parity, sign, carry, zero, out[3:0]} via integer math.
  function automatic logic [8:0] model(input logic [3:0] av, input logic [3:0] bv,
                                       input logic [1:0] sv);
    int ua, ub, sa, sb, r, sr;
    logic [3:0] o;
    logic c, v;
    ua = int'(av); ub = int'(bv);
    sa = av[3] ? ua - 16 : ua;
    sb = bv[3] ? ub - 16 : ub;
    r = 0; sr = 0; c = 1'b0; v = 1'b0;
    case (sv)
      2'b00: begin r = ua + ub; sr = sa + sb; c = (r > 15); v = (sr > 7) || (sr < -8); end
      2'b01: begin r = ua - ub; sr = sa - sb; c = (ua >= ub); v = (sr > 7) || (sr < -8); end
      2'b10: r = ua & ub;
      default: r = ua ^ ub;
    endcase
    o = r[3:0];
    return {v, ^o, o[3], c, (o == 4'h0), o};
  endfunction

  // Scoreboard: predict on request handshake, compare on response/stall.
  always @(negedge clk) begin
    logic [8:0] exp_v;
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected_rsp: got out=%b with no pending request", out);
        end else begin
          exp_v = sb_q[0];
          total++;
          if ({overflow, parity, sign, carry, zero, out} !== exp_v) begin
            bad++;
            $display("FAIL sb_rsp (ready=%b): got %b expected %b", rsp_ready,
                     {overflow, parity, sign, carry, zero, out}, exp_v);
          end
          if (rsp_ready) void'(sb_q.pop_front());
        end
      end
      if (req_valid && req_ready) sb_q.push_back(model(a, b, select));
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic [1:0] sv);
    logic acc;
    int guard;
    acc = 1'b0; guard = 0;
    req_valid = 1'b1; a = av; b = bv; select = sv;
    while (!acc && guard < 50) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", acc, guard);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if ({rsp_valid, out, zero, carry, sign, parity, overflow} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 0",
               {rsp_valid, out, zero, carry, sign, parity, overflow});
    end
    total++;
    if (txn_count !== 16'd0) begin bad++; $display("FAIL reset_txn: got %0d required 0", txn_count); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [3:0] ta[7] = '{4'b0111, 4'b0101, 4'b0010, 4'b1100, 4'b1100, 4'b1111, 4'b1000};
    logic [3:0] tb[7] = '{4'b0001, 4'b0101, 4'b0011, 4'b1010, 4'b1010, 4'b0001, 4'b0001};
    logic [1:0] ts[7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [3:0] to[7] = '{4'b1000, 4'b0000, 4'b1111, 4'b1000, 4'b0110, 4'b0000, 4'b0111};
    logic [4:0] tf[7] = '{5'b11100, 5'b00011, 5'b00100, 5'b01100, 5'b00000, 5'b00011, 5'b11010};
    rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(ta[i], tb[i], ts[i]);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL arith_early_valid[%0d]: got %b required 0", i, rsp_valid); end
      @(posedge clk); @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || out !== to[i]) begin
        bad++;
        $display("FAIL arith_out[%0d]: valid=%b out=%b required valid=1 out=%b", i, rsp_valid, out, to[i]);
      end
      total++;
      if ({overflow, parity, sign, carry, zero} !== tf[i]) begin
        bad++;
        $display("FAIL arith_flags[%0d]: got %b required %b", i, {overflow, parity, sign, carry, zero}, tf[i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (txn_count !== 16'd7) begin bad++; $display("FAIL arith_txn: got %0d required 7", txn_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [3:0] pa[3] = '{4'b0011, 4'b1111, 4'b0110};
    logic [3:0] pb[3] = '{4'b0100, 4'b0101, 4'b0011};
    logic [1:0] ps[3] = '{2'b00, 2'b11, 2'b10};
    logic       pr[3] = '{1'b1, 1'b1, 1'b0};
    int guard;
    apply_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; a = pa[i]; b = pb[i]; select = ps[i];
      @(negedge clk);
      total++;
      if (req_ready !== pr[i]) begin bad++; $display("FAIL bp_req_ready[%0d]: got %b required %b", i, req_ready, pr[i]); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || out !== 4'b0111 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b out=%b ready=%b required 1 0111 0", i, rsp_valid, out, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b required 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    @(negedge clk);
    total++;
    if (txn_count !== 16'd3 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_txn: txn=%0d valid=%b required txn=3 valid=0", txn_count, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        req_valid = 1'b1; a = 4'(k * 3 + 1); b = 4'(k + 5); select = 2'(k);
      end else begin
        req_valid = 1'b0;
      end
      exp_v = (k >= 2) && (k <= 5);
      @(negedge clk);
      total++;
      if (rsp_valid !== exp_v) begin bad++; $display("FAIL b2b_valid[%0d]: got %b required %b", k, rsp_valid, exp_v); end
      if (k < 4) begin
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b required 1", k, req_ready); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (txn_count !== 16'd4) begin bad++; $display("FAIL b2b_txn: got %0d required 4", txn_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    send(4'b0001, 4'b0010, 2'b00);
    send(4'b0011, 4'b0011, 2'b11);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_full: valid=%b ready=%b required 1 0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    apply_reset();
    @(negedge clk);
    total++;
    if ({rsp_valid, out, zero, carry, sign, parity, overflow} !== 10'b0 || txn_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset_state: outs=%b txn=%0d required 0 0",
               {rsp_valid, out, zero, carry, sign, parity, overflow}, txn_count);
    end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_req_ready: got %b required 1", req_ready); end
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got %b required 0", k, rsp_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drain();
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL drain: %0d responses pending, required 0", sb_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
